// File: rtl/quad_enc_pkg.sv
// Shared definitions for the quadrature encoder bank: decode modes and sizing helpers.
package quad_enc_pkg;

  typedef enum logic [1:0] {
    MODE_X4     = 2'b00,
    MODE_X2     = 2'b01,
    MODE_X1     = 2'b10,
    MODE_X4_ALT = 2'b11
  } mode_e;

  localparam int FCW = 4;  // filter run counter width, covers FILT up to 15

  function automatic int nbytes(input int cw);
    return cw / 8;
  endfunction

  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/quad_enc_chan.sv
// One encoder channel: input synchronisers, A/B glitch filters, decoder, wrapping counter, sticky err.
module quad_enc_chan import quad_enc_pkg::*; #(
  parameter int CW   = 16,
  parameter int SYNC = 2,
  parameter int FILT = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_a,
  input  logic          i_b,
  input  logic [1:0]    i_mode,
  output logic [CW-1:0] o_cnt,
  output logic          o_err
);

  // index 1 = A, index 0 = B throughout
  logic [1:0][SYNC-1:0] r_sync;
  logic [1:0][FCW-1:0]  r_fcnt;
  logic [1:0]           r_flt, r_flt_d;
  logic [1:0]           w_s, w_chg;
  logic                 w_inc, w_dec;
  logic [CW-1:0]        r_cnt;
  logic                 r_err;

  assign w_s   = {r_sync[1][SYNC-1], r_sync[0][SYNC-1]};
  assign w_chg = r_flt ^ r_flt_d;
  assign o_cnt = r_cnt;
  assign o_err = r_err;

  always_comb begin
    w_inc = 1'b0;
    w_dec = 1'b0;
    case (mode_e'(i_mode))
      MODE_X2: if (w_chg == 2'b10) begin
        w_inc = (r_flt[1] != r_flt[0]);
        w_dec = (r_flt[1] == r_flt[0]);
      end
      MODE_X1: if (w_chg == 2'b10 && r_flt[1]) begin
        w_inc = ~r_flt[0];
        w_dec = r_flt[0];
      end
      default: if (w_chg == 2'b10 || w_chg == 2'b01) begin
        // forward on 00->01->11->10->00 reduces to old A xor new B
        w_inc = r_flt_d[1] ^ r_flt[0];
        w_dec = ~(r_flt_d[1] ^ r_flt[0]);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync  <= '0;
      r_fcnt  <= '0;
      r_flt   <= '0;
      r_flt_d <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_sync[1] <= {r_sync[1][SYNC-2:0], i_a};
      r_sync[0] <= {r_sync[0][SYNC-2:0], i_b};
      for (int j = 0; j < 2; j++) begin
        if (w_s[j] == r_flt[j]) begin
          r_fcnt[j] <= '0;
        end else if (r_fcnt[j] == FCW'(FILT - 1)) begin
          r_flt[j]  <= w_s[j];
          r_fcnt[j] <= '0;
        end else begin
          r_fcnt[j] <= r_fcnt[j] + FCW'(1);
        end
      end
      r_flt_d <= r_flt;
      if (w_chg == 2'b11) r_err <= 1'b1;
      if (w_inc)      r_cnt <= r_cnt + CW'(1);
      else if (w_dec) r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/quad_enc_bank.sv
// Bank of NCH quadrature decoders with a lock-snapshot and byte-serial readout frame.
module quad_enc_bank import quad_enc_pkg::*; #(
  parameter int NCH  = 2,
  parameter int CW   = 16,
  parameter int SYNC = 2,
  parameter int FILT = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCH-1:0]          a,
  input  logic [NCH-1:0]          b,
  input  logic [1:0]              mode,
  input  logic                    lock,
  input  logic                    cs,
  input  logic                    rd,
  input  logic [sel_w(NCH)-1:0]   ch_sel,
  output logic [7:0]              dout,
  output logic                    dout_valid,
  output logic [NCH-1:0]          err
);

  localparam int NB = nbytes(CW);
  localparam int IW = sel_w(NB);
  localparam int SW = sel_w(NCH);

  logic [NCH-1:0][CW-1:0] w_cnt;
  logic [NCH-1:0][CW-1:0] r_snap;
  logic [2:0][SYNC-1:0]   r_sync;   // 2 = rd, 1 = cs, 0 = lock
  logic [2:0]             w_ctl, r_ctl_d;
  logic [SYNC-1:0]        r_fill;
  logic                   r_armed, r_frame;
  logic [SW-1:0]          r_sel;
  logic [IW-1:0]          r_idx, w_idx_nx;
  logic                   w_lock_rise, w_cs_rise, w_rd_rise;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    quad_enc_chan #(.CW(CW), .SYNC(SYNC), .FILT(FILT)) u_chan (
      .clk    (clk),
      .reset  (reset),
      .i_a    (a[g]),
      .i_b    (b[g]),
      .i_mode (mode),
      .o_cnt  (w_cnt[g]),
      .o_err  (err[g])
    );
  end

  function automatic logic [CW-1:0] snap_of(input logic [NCH-1:0][CW-1:0] s,
                                            input logic [SW-1:0] sel);
    snap_of = '0;
    for (int c = 0; c < NCH; c++)
      if (32'(sel) == c) snap_of = s[c];
  endfunction

  function automatic logic [7:0] pick(input logic [CW-1:0] w, input logic [IW-1:0] i);
    return w[8*int'(i) +: 8];
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_ctl
    assign w_ctl[k] = r_sync[k][SYNC-1];
  end

  // r_armed needs a genuine low cs after reset, so a frame held open through reset stays dead
  assign w_lock_rise = w_ctl[0] & ~r_ctl_d[0];
  assign w_cs_rise   = w_ctl[1] & ~r_ctl_d[1] & r_armed;
  assign w_rd_rise   = w_ctl[2] & ~r_ctl_d[2];
  assign w_idx_nx    = (r_idx == '0) ? IW'(NB - 1) : r_idx - IW'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync     <= '0;
      r_ctl_d    <= '0;
      r_fill     <= '0;
      r_armed    <= 1'b0;
      r_frame    <= 1'b0;
      r_snap     <= '0;
      r_sel      <= '0;
      r_idx      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      r_sync[0]  <= {r_sync[0][SYNC-2:0], lock};
      r_sync[1]  <= {r_sync[1][SYNC-2:0], cs};
      r_sync[2]  <= {r_sync[2][SYNC-2:0], rd};
      r_ctl_d    <= w_ctl;
      r_fill     <= {r_fill[SYNC-2:0], 1'b1};
      dout_valid <= 1'b0;
      if (w_lock_rise) r_snap <= w_cnt;
      if (r_fill[SYNC-1] && !w_ctl[1]) r_armed <= 1'b1;
      if (!w_ctl[1]) r_frame <= 1'b0;
      if (w_cs_rise) begin
        r_frame    <= 1'b1;
        r_sel      <= ch_sel;
        r_idx      <= IW'(NB - 1);
        dout       <= pick(snap_of(r_snap, ch_sel), IW'(NB - 1));
        dout_valid <= 1'b1;
      end else if (w_rd_rise && r_frame && w_ctl[1]) begin
        r_idx      <= w_idx_nx;
        dout       <= pick(snap_of(r_snap, r_sel), w_idx_nx);
        dout_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_quad_enc_bank.sv
// Directed bench for quad_enc_bank (NCH=2, CW=16, SYNC=2, FILT=3).
module tb_quad_enc_bank;

  localparam int NCH = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [NCH-1:0] a = '0, b = '0;
  logic [1:0]     mode = 2'b00;
  logic           lock = 1'b0, cs = 1'b0, rd = 1'b0;
  logic [0:0]     ch_sel = '0;
  logic [7:0]     dout;
  logic           dout_valid;
  logic [NCH-1:0] err;

  int n_run = 0, n_fail = 0, n_vld = 0;
  int v0;
  logic [1:0] st [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  quad_enc_bank #(.NCH(NCH), .CW(16), .SYNC(2), .FILT(3)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .mode(mode), .lock(lock),
    .cs(cs), .rd(rd), .ch_sel(ch_sel), .dout(dout), .dout_valid(dout_valid), .err(err)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (dout_valid) n_vld++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_vld(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (dout_valid) ok = 1'b1;
    end
    if (!ok) chk({tag, "_timeout"}, 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic open_frame(input int sel, input string tag, input logic [7:0] exp);
    ch_sel = 1'(sel);
    cs = 1'b1;
    wait_vld(tag);
    chk(tag, dout, exp);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] exp);
    rd = 1'b1;
    wait_vld(tag);
    rd = 1'b0;
    tick(4);
    chk(tag, dout, exp);
  endtask

  task automatic close_frame();
    cs = 1'b0;
    tick(4);
  endtask

  task automatic read_word(input int sel, input string tag, input logic [15:0] exp);
    open_frame(sel, {tag, "_msb"}, exp[15:8]);
    rd_chk({tag, "_lsb"}, exp[7:0]);
    close_frame();
  endtask

  task automatic do_lock();
    lock = 1'b1; tick(5);
    lock = 1'b0; tick(5);
  endtask

  task automatic do_reset();
    a = '0; b = '0; cs = 1'b0; rd = 1'b0; lock = 1'b0;
    reset = 1'b0; tick(3);
    reset = 1'b1; tick(4);
  endtask

  // forward x4 steps along 00->01->11->10->00 ({A,B}) from the current level
  task automatic fwd(input int ch, input int n);
    int k = 0;
    for (int i = 0; i < 4; i++) if (st[i] == {a[ch], b[ch]}) k = i;
    repeat (n) begin
      k = (k + 1) % 4;
      a[ch] = st[k][1];
      b[ch] = st[k][0];
      tick(8);
    end
  endtask

  initial begin
    tick(3);
    reset = 1'b1;
    tick(4);
    chk("rst_dout", dout, 8'h00);
    chk("rst_vld", dout_valid, 1'b0);
    chk("rst_err", err, 2'b00);

    // x4: 8 forward steps, then 3 rd in one frame
    fwd(0, 8);
    do_lock();
    v0 = n_vld;
    open_frame(0, "x4_b0", 8'h00);
    rd_chk("x4_b1", 8'h08);
    rd_chk("x4_b2", 8'h00);
    rd_chk("x4_b3", 8'h08);
    chk("x4_vld_cnt", n_vld - v0, 4);
    close_frame();
    chk("hold_after_cs", dout, 8'h08);
    read_word(1, "ch1_zero", 16'h0000);

    // simultaneous A/B change on ch1
    a[1] = 1'b1; b[1] = 1'b1; tick(10);
    chk("err_set", err, 2'b10);
    tick(10);
    chk("err_sticky", err, 2'b10);
    do_lock();
    read_word(1, "ch1_illegal", 16'h0000);
    read_word(0, "ch0_keep", 16'h0008);
    do_reset();
    chk("err_clr", err, 2'b00);

    // x1: A rising with B=1 counts down, four full cycles wrap below zero
    mode = 2'b10;
    fwd(0, 16);
    do_lock();
    read_word(0, "x1_wrap", 16'hFFFC);

    // x1 glitch filter on ch1 with B=0
    a[1] = 1'b1; tick(2); a[1] = 1'b0; tick(10);
    do_lock();
    read_word(1, "glitch_short", 16'h0000);
    a[1] = 1'b1; tick(3); a[1] = 1'b0; tick(10);
    do_lock();
    read_word(1, "glitch_filt", 16'h0001);

    // x2: one forward cycle, both A edges land with A==B
    do_reset();
    mode = 2'b01;
    fwd(0, 4);
    do_lock();
    read_word(0, "x2_cycle", 16'hFFFE);

    // mode 11 decodes as x4
    do_reset();
    mode = 2'b11;
    fwd(0, 2);
    do_lock();
    read_word(0, "m11_x4", 16'h0002);

    // count 0x00FF->0x0100 and lock landing in the same cycle
    do_reset();
    mode = 2'b00;
    fwd(0, 255);
    a[0] = 1'b0; b[0] = 1'b0;
    tick(3);
    lock = 1'b1; tick(5);
    lock = 1'b0; tick(8);
    read_word(0, "same_cyc", 16'h00FF);
    open_frame(0, "mid_msb", 8'h00);
    do_lock();
    chk("mid_hold", dout, 8'h00);
    rd_chk("mid_lsb_new", 8'h00);
    rd_chk("mid_msb_new", 8'h01);
    close_frame();

    // reset mid-frame aborts; cs held high must not restart a frame
    open_frame(0, "abort_open", 8'h01);
    reset = 1'b0; tick(3);
    reset = 1'b1;
    v0 = n_vld;
    tick(20);
    chk("abort_no_vld", n_vld - v0, 0);
    chk("abort_dout", dout, 8'h00);
    close_frame();
    read_word(0, "abort_fresh", 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
